// File: rtl/tetris_pkg.sv
// Shared piece codes, LFSR taps and bag bookkeeping helpers for the piece generators.
package tetris_pkg;

    typedef enum logic [2:0] {
        I = 3'd0,
        O = 3'd1,
        T = 3'd2,
        S = 3'd3,
        Z = 3'd4,
        J = 3'd5,
        L = 3'd6
    } piece_t;

    localparam int          NUM_PIECES_STD = 7;
    localparam int          MAX_TYPES      = 8;
    localparam int          USED_W         = 3;
    localparam logic [15:0] LFSR_TAPS      = 16'hB400;

    typedef logic [MAX_TYPES-1:0][USED_W-1:0] used_vec_t;

    // Lowest type still below its copy limit; callers mark types outside the set as full.
    function automatic logic [2:0] lowest_legal(input used_vec_t used, input int copies);
        logic [2:0] idx;
        idx = '0;
        for (int i = MAX_TYPES - 1; i >= 0; i--) begin
            if (32'(used[i]) < copies) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/galois_lfsr.sv
// Right-shifting Galois LFSR that advances every cycle; a zero seed is replaced by 1.
module galois_lfsr #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(16'hB400),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] lfsr
);

    localparam logic [WIDTH-1:0] SEED_NZ = (SEED == '0) ? WIDTH'(1) : SEED;

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q >> 1;
        if (lfsr_q[0]) lfsr_d = (lfsr_q >> 1) ^ TAPS;
        if (load) lfsr_d = (load_val == '0) ? WIDTH'(1) : load_val;
    end

    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= SEED_NZ;
        else       lfsr_q <= lfsr_d;
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/bag_randomizer.sv
// Bag-based piece generator: LFSR candidates filtered by per-type copy counts, fed into
// a shift-register preview FIFO with a valid/ready head.
module bag_randomizer
    import tetris_pkg::*;
#(
    parameter int          NUM_PIECES = 7,
    parameter int          PIECE_W    = 3,
    parameter int          COPIES     = 1,
    parameter int          PREVIEW    = 3,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          MAX_TRIES  = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   mode,
    input  logic                                   seed_load,
    input  logic [15:0]                            seed_val,
    input  logic                                   piece_ready,
    output logic                                   piece_valid,
    output logic [PIECE_W-1:0]                     piece,
    output logic [PREVIEW*PIECE_W-1:0]             preview,
    output logic [PREVIEW-1:0]                     preview_valid,
    output logic [$clog2(NUM_PIECES*COPIES+1)-1:0] bag_remaining,
    output logic                                   bag_done,
    output logic [7:0]                             bag_count
);

    localparam int DEPTH    = PREVIEW + 1;
    localparam int BAG_SIZE = NUM_PIECES * COPIES;
    localparam int REM_W    = $clog2(BAG_SIZE + 1);
    localparam int CNT_W    = $clog2(DEPTH + 1);
    localparam int TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    logic [PIECE_W-1:0] fifo_q [DEPTH];
    logic [PIECE_W-1:0] fifo_d [DEPTH];
    logic [CNT_W-1:0]   count_q, count_d;
    used_vec_t          used_q, used_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [TRY_W-1:0]   try_q, try_d;
    logic               bag_done_q, bag_done_d;
    logic [7:0]         bag_count_q, bag_count_d;

    logic [15:0]        lfsr;
    logic               lfsr_unused;
    logic [PIECE_W-1:0] cand;
    logic [PIECE_W-1:0] new_piece;
    logic [2:0]         cand_idx;
    logic [2:0]         new_idx;
    logic [CNT_W-1:0]   wr_idx;
    used_vec_t          used_mask;
    logic               pop, draw_en, in_range, legal, last_try, accept;

    galois_lfsr #(
        .WIDTH (16),
        .TAPS  (LFSR_TAPS),
        .SEED  (SEED)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (seed_load),
        .load_val (seed_val),
        .lfsr     (lfsr)
    );

    assign lfsr_unused = ^lfsr[15:PIECE_W];

    always_comb begin
        pop      = (count_q != '0) && piece_ready;
        draw_en  = (32'(count_q) < DEPTH) || pop;
        cand     = lfsr[PIECE_W-1:0];
        cand_idx = 3'(cand);
        in_range = 32'(cand) < NUM_PIECES;
        for (int i = 0; i < MAX_TYPES; i++) begin
            used_mask[i] = (i < NUM_PIECES) ? used_q[i] : USED_W'(COPIES);
        end
        // Random mode ignores the copy limits; its fallback is simply type 0.
        legal     = in_range && (mode || (32'(used_q[cand_idx]) < COPIES));
        last_try  = (32'(try_q) == MAX_TRIES - 1);
        accept    = draw_en && (legal || last_try);
        new_piece = legal ? cand
                  : (mode ? '0 : PIECE_W'(lowest_legal(used_mask, COPIES)));
        new_idx   = 3'(new_piece);
        wr_idx    = count_q - CNT_W'(pop);

        fifo_d      = fifo_q;
        count_d     = count_q + CNT_W'(accept) - CNT_W'(pop);
        used_d      = used_q;
        rem_d       = rem_q;
        try_d       = try_q;
        bag_done_d  = 1'b0;
        bag_count_d = bag_count_q;

        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) fifo_d[i] = fifo_q[i+1];
            fifo_d[DEPTH-1] = '0;
        end
        if (accept) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (32'(wr_idx) == i) fifo_d[i] = new_piece;
            end
        end

        if (draw_en) try_d = accept ? '0 : try_q + TRY_W'(1);

        // The refill lands in the same update as the last draw, so 0 is never visible.
        if (accept && !mode) begin
            if (rem_q == REM_W'(1)) begin
                used_d      = '0;
                rem_d       = REM_W'(BAG_SIZE);
                bag_done_d  = 1'b1;
                bag_count_d = bag_count_q + 8'd1;
            end else begin
                used_d[new_idx] = used_q[new_idx] + USED_W'(1);
                rem_d           = rem_q - REM_W'(1);
            end
        end

        if (seed_load) begin
            for (int i = 0; i < DEPTH; i++) fifo_d[i] = '0;
            count_d     = '0;
            used_d      = '0;
            rem_d       = REM_W'(BAG_SIZE);
            try_d       = '0;
            bag_done_d  = 1'b0;
            bag_count_d = bag_count_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_q      <= '{default: '0};
            count_q     <= '0;
            used_q      <= '0;
            rem_q       <= REM_W'(BAG_SIZE);
            try_q       <= '0;
            bag_done_q  <= 1'b0;
            bag_count_q <= '0;
        end else begin
            fifo_q      <= fifo_d;
            count_q     <= count_d;
            used_q      <= used_d;
            rem_q       <= rem_d;
            try_q       <= try_d;
            bag_done_q  <= bag_done_d;
            bag_count_q <= bag_count_d;
        end
    end

    always_comb begin
        piece_valid   = (count_q != '0);
        piece         = piece_valid ? fifo_q[0] : '0;
        preview       = '0;
        preview_valid = '0;
        for (int k = 0; k < PREVIEW; k++) begin
            preview_valid[k] = 32'(count_q) > k + 1;
            if (preview_valid[k]) preview[k*PIECE_W +: PIECE_W] = fifo_q[k+1];
        end
    end

    assign bag_remaining = rem_q;
    assign bag_done      = bag_done_q;
    assign bag_count     = bag_count_q;

endmodule

// File: doc/bag_randomizer.md
Name: bag_randomizer

Overview:
- Parametrised successor to the 7-bag piece generator: draws pieces internally from an LFSR, never from a driven piece input.
- Each bag holds every piece type COPIES times and is refilled automatically. A pure-random mode is also available.
- Output is a preview FIFO with a valid/ready handshake. It sits between the game FSM (consumer of next piece) and the next-piece display (consumer of preview).

Parameters:
- NUM_PIECES, 7, number of piece types (2..8)
- PIECE_W, 3, piece code width; must satisfy 2**PIECE_W >= NUM_PIECES
- COPIES, 1, copies of each type per bag (1..4)
- PREVIEW, 3, visible lookahead entries behind the head (1..6); FIFO depth = PREVIEW+1
- SEED, 16'hACE1, LFSR reset value; 0 is forced to 1
- MAX_TRIES, 4, rejection attempts before deterministic fallback (>=1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mode  in  1  0 = bag mode, 1 = pure random; sampled per draw
- seed_load  in  1  load seed_val into LFSR, flush FIFO, clear bag
- seed_val  in  16  seed for seed_load; 0 is loaded as 1
- piece_ready  in  1  consumer accepts head this cycle
- piece_valid  out  1  head entry present (FIFO count > 0)
- piece  out  PIECE_W  head piece code; 0 when !piece_valid
- preview  out  PREVIEW*PIECE_W  entries 1..PREVIEW behind head; slot 0 at LSBs; empty slots read 0
- preview_valid  out  PREVIEW  bit k set when preview slot k holds an entry
- bag_remaining  out  $clog2(NUM_PIECES*COPIES+1)  draws left in current bag
- bag_done  out  1  one-cycle pulse when the last piece of a bag is drawn
- bag_count  out  8  completed bags, wraps 255 -> 0

Behaviour:
- Reset values:
  - FIFO empty; piece_valid=0, piece=0, preview=0, preview_valid=0
  - bag_remaining=NUM_PIECES*COPIES; bag_done=0; bag_count=0
  - LFSR=SEED; used counters=0; try counter=0
- Priority: reset > seed_load > normal operation.
- seed_load for one cycle acts like reset, except the LFSR takes seed_val and bag_count holds its value. Outputs reflect the flushed state next cycle.
- LFSR: 16-bit Galois, taps 16'hB400, shifts every cycle including stall and reject cycles. Candidate = lfsr[PIECE_W-1:0].
- Draw: one attempt per cycle while FIFO count < DEPTH, or count == DEPTH and pop this cycle.
  - Bag mode rejects a candidate if candidate >= NUM_PIECES or used[candidate] == COPIES.
  - Random mode rejects only candidate >= NUM_PIECES.
  - On reject, try counter increments.
  - On the attempt with try counter == MAX_TRIES-1, a rejected candidate is replaced by the lowest-index legal type. Every draw therefore completes within MAX_TRIES cycles.
  - On accept: push to FIFO tail; try counter clears. In bag mode only, used[type]++ and bag_remaining--.
- Bag refill (bag mode):
  - On the cycle the draw takes bag_remaining from 1 to 0, bag_done=1 next cycle and bag_count++.
  - Used counters clear and bag_remaining reloads to NUM_PIECES*COPIES in that same update, so no cycle shows 0.
- Mode switch to random mid-bag: used counters freeze. Switching back resumes the partial bag. bag_done never pulses in random mode.
- Handshake:
  - Pop on piece_valid && piece_ready. piece_ready while !piece_valid has no effect.
  - Push and pop in the same cycle are allowed when full. Count is unchanged and the entries shift.
  - The head is stable while piece_valid && !piece_ready.
- Fill latency: from reset release, piece_valid rises within MAX_TRIES cycles. With ready held low, the FIFO is full within DEPTH*MAX_TRIES cycles.

Decomposition:
- tetris_pkg holds:
  - piece_t enum I=0, O=1, T=2, S=3, Z=4, J=5, L=6
  - NUM_PIECES_STD=7
  - LFSR_TAPS=16'hB400
  - function lowest_legal(used, COPIES)
- Sub-module galois_lfsr (width 16, taps and seed parameters, load/load_val ports).
- FIFO and bag bookkeeping stay in bag_randomizer.

Test Plan:
- Reset then ready=1 for 7 pops (NUM_PIECES=7, COPIES=1): pieces are a permutation of 0..6. bag_done pulses exactly once, the cycle after the 7th draw. bag_count=1. bag_remaining returns to 7.
- Consume 70 pieces with COPIES=2: each 14-piece window contains every type exactly twice. bag_count=5.
- ready=0 after reset: piece_valid=1 within 4 cycles; preview_valid=3'b111 within 16 cycles. Head and preview hold constant for 20 further cycles.
- Force the LFSR to a seed yielding only used or illegal candidates with one type left: fallback selects that type on the 4th attempt, never later.
- seed_load with seed_val=0 mid-bag: next cycle FIFO is empty, bag_remaining=7, LFSR=1, bag_count unchanged. Two loads of the same seed produce an identical 21-piece sequence.
- mode=1 for 100 pops: all codes < 7, bag_done stays 0, bag_remaining is frozen. Return to mode=0 and the partial bag completes correctly.
